// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: register-file widths and the writeback request type
package regfile_wb_arbiter_pkg;
    localparam int XLEN = 64;
    localparam int NREGS = 32;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: valid/ready writeback bus shared by all requesters
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 2,
    parameter int XLEN = 64
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*5-1:0]    req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    modport master (output req_valid, req_rd, req_data, input req_ready);
    modport slave (input req_valid, req_rd, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starts at the slot after the last winner
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] valid,
    output logic [N-1:0] grant
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW:0]   s;
    logic          found;
    always_comb begin
        grant = '0;
        found = 1'b0;
        win = '0;
        s = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr} + (PW+1)'(k);
            s = s >= (PW+1)'(N) ? s - (PW+1)'(N) : s;
            if (!found && !reset && valid[s[PW-1:0]]) begin
                grant[s[PW-1:0]] = 1'b1;
                found = 1'b1;
                win = s[PW-1:0];
            end
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset)
            ptr <= '0;
        else if (found)
            ptr <= win == PW'(N-1) ? '0 : win + 1'b1;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the register-file write port and the pending-write scoreboard
module regfile_wb_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 alloc_valid,
    input  logic [4:0]           alloc_rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [31:0]          busy_vec,
    output logic                 wr_en,
    output logic [4:0]           wr_rd,
    output logic [XLEN-1:0]      wr_data
);
    import regfile_wb_arbiter_pkg::*;
    wb_req_t          sel;
    logic             any;
    logic [NREGS-1:0] busy_nxt;
    rr_arbiter #(.N(NREQ)) u_arb (
        .clk(clk),
        .reset(reset),
        .valid(wb.req_valid),
        .grant(wb.req_ready)
    );
    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (wb.req_ready[i])
                sel = {wb.req_rd[i*REG_IDX_W +: REG_IDX_W], wb.req_data[i*XLEN +: XLEN]};
    end
    assign any = |wb.req_ready;
    // set after clear so a new producer allocated at the commit edge stays pending
    always_comb begin
        busy_nxt = busy_vec;
        if (wr_en)
            busy_nxt[wr_rd] = 1'b0;
        if (alloc_valid)
            busy_nxt[alloc_rd] = 1'b1;
        busy_nxt[ZERO_REG] = 1'b0;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_en <= 1'b0;
            wr_rd <= '0;
            wr_data <= '0;
            busy_vec <= '0;
        end else begin
            wr_en <= any && sel.rd != ZERO_REG;
            wr_rd <= any ? sel.rd : wr_rd;
            wr_data <= any ? sel.data : wr_data;
            busy_vec <= busy_nxt;
        end
    assign rs1_busy = busy_vec[rs1];
    assign rs2_busy = busy_vec[rs2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a write scoreboard and direct handshake/scoreboard checks
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;
    localparam logic [63:0] D0 = 64'hA0A0_0000_0000_0005;
    localparam logic [63:0] D1 = 64'hB1B1_0000_0000_0006;
    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic [4:0]  alloc_rd, rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic [31:0] busy_vec;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [63:0] wr_data;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    wb_req_t     exp_q[$];
    wb_req_t     e;
    regfile_wb_arbiter_if #(.NREQ(2), .XLEN(64)) wb ();
    regfile_wb_arbiter #(.NREQ(2), .XLEN(64)) dut (
        .clk(clk),
        .reset(reset),
        .wb(wb),
        .alloc_valid(alloc_valid),
        .alloc_rd(alloc_rd),
        .rs1(rs1),
        .rs2(rs2),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .busy_vec(busy_vec),
        .wr_en(wr_en),
        .wr_rd(wr_rd),
        .wr_data(wr_data)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        total_cnt++;
        if (a === x)
            pass_cnt++;
        else
            $display("FAIL %s actual=%0h expected=%0h", n, a, x);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk)
        if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write actual rd=%0d data=%0h expected none", wr_rd, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_rd", 64'(wr_rd), 64'(e.rd));
                chk("wr_data", wr_data, e.data);
            end
        end
    initial begin
        reset = 1'b1;
        alloc_valid = 1'b0;
        alloc_rd = 5'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        wb.req_valid = 2'b11;
        wb.req_rd = {5'd6, 5'd5};
        wb.req_data = {D1, D0};
        #2;
        chk("rst_ready", 64'(wb.req_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_busy", 64'(busy_vec), 64'd0);
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", 64'(wb.req_ready), (k % 2) != 0 ? 64'd2 : 64'd1);
            exp_q.push_back((k % 2) != 0 ? {5'd6, D1} : {5'd5, D0});
            step();
        end
        wb.req_valid = 2'b00;
        #1;
        chk("rr_last_wr_en", 64'(wr_en), 64'd1);
        step();
        chk("rr_idle_wr_en", 64'(wr_en), 64'd0);
        wb.req_valid = 2'b01;
        wb.req_rd = {5'd0, 5'd3};
        wb.req_data = {64'd0, 64'hDEADBEEF_00000001};
        #1;
        chk("single_grant", 64'(wb.req_ready), 64'd1);
        exp_q.push_back({5'd3, 64'hDEADBEEF_00000001});
        step();
        wb.req_valid = 2'b00;
        #1;
        chk("single_wr_en", 64'(wr_en), 64'd1);
        step();
        chk("single_idle", 64'(wr_en), 64'd0);
        alloc_valid = 1'b1;
        alloc_rd = 5'd0;
        step();
        alloc_valid = 1'b0;
        #1;
        chk("x0_alloc_busy", 64'(busy_vec), 64'd0);
        wb.req_valid = 2'b10;
        wb.req_rd = {5'd0, 5'd0};
        wb.req_data = {64'hFFFF, 64'd0};
        #1;
        chk("x0_grant", 64'(wb.req_ready), 64'd2);
        step();
        wb.req_valid = 2'b00;
        #1;
        chk("x0_wr_en", 64'(wr_en), 64'd0);
        chk("x0_busy", 64'(busy_vec), 64'd0);
        alloc_valid = 1'b1;
        alloc_rd = 5'd7;
        rs1 = 5'd7;
        rs2 = 5'd7;
        #1;
        chk("sb_no_fwd", 64'(rs1_busy), 64'd0);
        step();
        alloc_valid = 1'b0;
        #1;
        chk("sb_rs1_busy", 64'(rs1_busy), 64'd1);
        chk("sb_vec", 64'(busy_vec), 64'h80);
        wb.req_valid = 2'b01;
        wb.req_rd = {5'd0, 5'd7};
        wb.req_data = {64'd0, 64'h7777};
        #1;
        chk("sb_grant", 64'(wb.req_ready), 64'd1);
        chk("sb_rs2_busy_t", 64'(rs2_busy), 64'd1);
        exp_q.push_back({5'd7, 64'h7777});
        step();
        wb.req_valid = 2'b00;
        #1;
        chk("sb_busy_t1", 64'(busy_vec), 64'h80);
        step();
        chk("sb_busy_t2", 64'(busy_vec), 64'd0);
        chk("sb_rs1_clear", 64'(rs1_busy), 64'd0);
        alloc_valid = 1'b1;
        alloc_rd = 5'd9;
        step();
        alloc_valid = 1'b0;
        wb.req_valid = 2'b10;
        wb.req_rd = {5'd9, 5'd0};
        wb.req_data = {64'h9999, 64'd0};
        #1;
        chk("col_busy", 64'(busy_vec), 64'h200);
        chk("col_grant", 64'(wb.req_ready), 64'd2);
        exp_q.push_back({5'd9, 64'h9999});
        step();
        wb.req_valid = 2'b00;
        alloc_valid = 1'b1;
        alloc_rd = 5'd9;
        #1;
        chk("col_wr_en", 64'(wr_en), 64'd1);
        step();
        alloc_valid = 1'b0;
        #1;
        chk("col_set_wins", 64'(busy_vec), 64'h200);
        wb.req_valid = 2'b01;
        wb.req_rd = {5'd0, 5'd10};
        wb.req_data = {64'd0, 64'hAAAA};
        alloc_valid = 1'b1;
        alloc_rd = 5'd12;
        #1;
        chk("mid_grant_a", 64'(wb.req_ready), 64'd1);
        exp_q.push_back({5'd10, 64'hAAAA});
        step();
        alloc_valid = 1'b0;
        #1;
        chk("mid_grant_b", 64'(wb.req_ready), 64'd1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        wb.req_valid = 2'b11;
        wb.req_rd = {5'd11, 5'd10};
        wb.req_data = {64'hBBBB, 64'hAAAA};
        #1;
        chk("mid_rst_ready", 64'(wb.req_ready), 64'd0);
        chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
        chk("mid_rst_wr_rd", 64'(wr_rd), 64'd0);
        chk("mid_rst_wr_data", wr_data, 64'd0);
        chk("mid_rst_busy", 64'(busy_vec), 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rel_first_grant", 64'(wb.req_ready), 64'd1);
        exp_q.push_back({5'd10, 64'hAAAA});
        step();
        wb.req_valid = 2'b00;
        step();
        step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sole owner of the integer register file's single write port (64-bit data, 32 entries, x0 hardwired-zero semantics).
- Arbitrates round-robin among N writeback requesters (ALU, load unit, ...) using valid/ready handshakes, then drives a registered write (RegWrite/RD/WriteData) into the register file.
- Also keeps a 32-bit pending-write scoreboard so the issue stage can stall on RAW hazards against writes not yet committed.

Parameters:
- NREQ, 2, number of writeback requesters (2..4)
- XLEN, 64, register data width
- NREGS, 32, architectural registers; index width 5

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  requester i has a writeback pending
- req_rd  input  NREQ*5  destination register of requester i (slice i*5 +: 5)
- req_data  input  NREQ*XLEN  write data of requester i (slice i*XLEN +: XLEN)
- req_ready  output  NREQ  one-hot grant; transfer when valid & ready
- alloc_valid  input  1  issue stage dispatches an instruction that will write alloc_rd
- alloc_rd  input  5  destination being allocated
- rs1  input  5  issue-stage source 1 query
- rs2  input  5  issue-stage source 2 query
- rs1_busy  output  1  rs1 has an uncommitted write (combinational)
- rs2_busy  output  1  rs2 has an uncommitted write (combinational)
- busy_vec  output  32  full scoreboard, bit r = register r pending
- wr_en  output  1  register-file RegWrite
- wr_rd  output  5  register-file RD
- wr_data  output  XLEN  register-file WriteData

Behaviour:
- Reset (async, active-high): wr_en=0, wr_rd=0, wr_data=0, busy_vec=0, round-robin pointer=0. req_ready is combinational and therefore 0 while reset is high. Reset mid-transfer discards any in-flight write; no partial state survives.
- Arbitration:
  - Combinational, at most one grant per cycle.
  - Search starts at pointer p: first i in p, p+1, ..., wrapping modulo NREQ, with req_valid[i]=1 receives req_ready[i]=1.
  - No valid requesters means req_ready=0.
  - After a grant to i, p <= (i+1) mod NREQ. p is unchanged when there is no grant.
- Handshake:
  - A requester holds valid, rd and data stable until it sees ready.
  - ready never depends on a requester's own data.
  - req_ready is never asserted without the matching req_valid.
- Write path (latency 1):
  - A grant in cycle T gives wr_en=1, wr_rd=rd, wr_data=data in cycle T+1. The register file captures the write on the following edge.
  - Cycles with no grant give wr_en=0. wr_rd/wr_data hold their previous values.
  - Grant with rd=0: the transfer is accepted (ready=1, pointer advances) but wr_en stays 0 in T+1.
- Scoreboard:
  - Set: at the edge where alloc_valid=1 and alloc_rd!=0, busy[alloc_rd] <= 1.
  - Clear: at the edge where wr_en=1 (and wr_rd!=0), busy[wr_rd] <= 0.
  - Same register set and cleared at the same edge: set wins (bit stays 1, the new producer is pending).
  - alloc to x0 is ignored. busy[0] is constant 0.
  - Re-allocating an already-busy register leaves the bit at 1. No counting: the issue stage must not issue a second writer to a busy rd.
  - rsN_busy = busy[rsN]; the value reflects the current registered state only (no same-cycle alloc forwarding).
- Width rules: rd/rs fields are 5 bits unsigned; data passes through unmodified; no arithmetic beyond pointer increment modulo NREQ.

Decomposition:
- Shared package holds: XLEN, NREGS, REG_IDX_W=5, ZERO_REG=5'd0, and a wb_req struct/typedef {rd[4:0], data[XLEN-1:0]}.
- One natural sub-module: rr_arbiter (NREQ-wide round-robin: valid vector in, one-hot grant out, pointer register inside). The scoreboard stays inline.

Test Plan:
- Reset: assert reset mid-stream with req_valid=2'b11 -> req_ready=0, wr_en=0, busy_vec=0 immediately; after release the first grant goes to requester 0.
- Round-robin fairness: req_valid=2'b11 held 4 cycles (rd 5 and 6) -> grants alternate 0,1,0,1; wr_en=1 each following cycle, wr_rd alternates 5,6.
- Single write: req0 rd=3 data=64'hDEADBEEF_00000001 in cycle T -> wr_en=1, wr_rd=3, wr_data=64'hDEADBEEF_00000001 at T+1; wr_en=0 at T+2.
- x0 suppression: alloc rd=0, then req1 rd=0 data=64'hFFFF -> busy_vec stays 0, req_ready[1]=1, wr_en stays 0.
- Scoreboard: alloc rd=7 -> rs1=7 gives rs1_busy=1; req0 rd=7 granted at T -> busy[7]=1 during T+1, 0 from T+2.
- Set/clear collision: wr_en=1 with wr_rd=9 in the same cycle as alloc_rd=9 -> busy[9] stays 1.
